// File: rtl/riscv_defines.sv
// Shared typedefs and default constants for the core's memory-side blocks.
package riscv_defines;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_DATA  = 2'd1,
        OWN_FETCH = 2'd2
    } arb_owner_t;

    // Which requester drives the SRAM port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_PROG  = 2'd1,
        GNT_DATA  = 2'd2,
        GNT_FETCH = 2'd3
    } arb_gnt_t;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter: prog > data > fetch, with a fetch anti-starvation
// override, and one-cycle-later read-data routing to the requester that issued it.
module mem_port_arbiter
    import riscv_defines::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              start,
    input  logic              prog_req,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_wdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_stall,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_stall,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output arb_owner_t        dbg_owner,
    output logic [3:0]        dbg_starve_cnt
);

    // Handshake: a request is consumed in the cycle its gnt is 1; a stalled
    // requester holds req/addr/data stable. rvalid follows a read gnt by one cycle.

    // STARVE_LIMIT must lie in 1..15 to fit the 4-bit counter.
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_owner_t owner;
    logic [3:0] starve_cnt;
    arb_gnt_t   gnt;

    always_comb begin
        gnt = GNT_NONE;
        if (!start)
            gnt = GNT_NONE;
        else if (prog_req)
            gnt = GNT_PROG;
        else if (d_req && i_req)
            gnt = (starve_cnt == LIMIT) ? GNT_FETCH : GNT_DATA;
        else if (d_req)
            gnt = GNT_DATA;
        else if (i_req)
            gnt = GNT_FETCH;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        unique case (gnt)
            GNT_PROG: begin
                mem_en    = 1'b1;
                mem_we    = 4'hF;
                mem_addr  = prog_addr[ADDR_W-1:2];
                mem_wdata = prog_wdata;
            end
            GNT_DATA: begin
                mem_en    = 1'b1;
                mem_we    = d_we ? d_be : 4'h0;
                mem_addr  = d_addr[ADDR_W-1:2];
                mem_wdata = d_wdata;
            end
            GNT_FETCH: begin
                mem_en   = 1'b1;
                mem_addr = i_addr[ADDR_W-1:2];
            end
            default: ;
        endcase
    end

    assign d_gnt   = (gnt == GNT_DATA);
    assign i_gnt   = (gnt == GNT_FETCH);
    assign d_stall = start & d_req & ~d_gnt;
    assign i_stall = start & i_req & ~i_gnt;

    // Outputs are gated by start so nothing leaks out while held in reset.
    assign d_rvalid = start && (owner == OWN_DATA);
    assign i_rvalid = start && (owner == OWN_FETCH);
    assign d_rdata  = d_rvalid ? mem_rdata : 32'h0;
    assign i_rdata  = i_rvalid ? mem_rdata : 32'h0;

    assign dbg_owner      = start ? owner : OWN_NONE;
    assign dbg_starve_cnt = start ? starve_cnt : 4'h0;

    always_ff @(posedge clk) begin
        if (!start) begin
            owner      <= OWN_NONE;
            starve_cnt <= 4'h0;
        end else begin
            if (gnt == GNT_DATA && !d_we)
                owner <= OWN_DATA;
            else if (gnt == GNT_FETCH)
                owner <= OWN_FETCH;
            else
                owner <= OWN_NONE;

            if (gnt == GNT_FETCH)
                starve_cnt <= 4'h0;
            else if (gnt == GNT_DATA && i_req && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'h1;
        end
    end

    // Word addressing drops the byte-offset bits.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{prog_addr[1:0], d_addr[1:0], i_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: driver + reference model feed an expected queue,
// a negedge monitor pops and compares; a small SRAM model closes the read loop.
module tb_mem_port_arbiter;
    import riscv_defines::*;

    localparam int ADDR_W = 32;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              start;
    logic              prog_req;
    logic [ADDR_W-1:0] prog_addr;
    logic [31:0]       prog_wdata;
    logic              d_req, d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt, d_stall, d_rvalid;
    logic [31:0]       d_rdata;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt, i_stall, i_rvalid;
    logic [31:0]       i_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    arb_owner_t        dbg_owner;
    logic [3:0]        dbg_starve_cnt;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .start(start),
        .prog_req(prog_req), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_stall(d_stall), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_stall(i_stall),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_owner(dbg_owner), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- SRAM model (64 words) ----------------
    logic        sram_load;
    logic [31:0] sram [64];

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h01234567;
    endfunction

    always @(posedge clk) begin
        if (sram_load) begin
            for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
            mem_rdata <= 32'h0;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) sram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_we == 4'h0) mem_rdata <= sram[mem_addr[5:0]];
        end
    end

    // ---------------- reference model + expected queue ----------------
    typedef struct packed {
        logic        d_gnt, d_stall, i_gnt, i_stall, mem_en;
        logic [3:0]  mem_we;
        logic [29:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        chk_wdata;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        i_rvalid;
        logic [31:0] i_rdata;
        logic [3:0]  cnt;
        arb_owner_t  owner;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] shadow [64];
    int          m_pend;       // 0 none, 1 data load in flight, 2 fetch in flight
    logic [31:0] m_pend_data;
    int          m_losses;     // consecutive fetch losses to data
    int          m_win;        // 0 none, 1 prog, 2 data, 3 fetch
    int          total = 0;
    int          bad   = 0;

    task automatic step();
        exp_t e;
        int   idx;
        e = '0;
        m_win = 0;
        if (start) begin
            e.cnt   = 4'(m_losses);
            e.owner = (m_pend == 1) ? OWN_DATA : (m_pend == 2) ? OWN_FETCH : OWN_NONE;
            if (m_pend == 1) begin e.d_rvalid = 1'b1; e.d_rdata = m_pend_data; end
            if (m_pend == 2) begin e.i_rvalid = 1'b1; e.i_rdata = m_pend_data; end
            if (prog_req) m_win = 1;
            else if (d_req && i_req) m_win = (m_losses == LIMIT) ? 3 : 2;
            else if (d_req) m_win = 2;
            else if (i_req) m_win = 3;
            e.d_gnt     = (m_win == 2);
            e.i_gnt     = (m_win == 3);
            e.d_stall   = d_req && m_win != 2;
            e.i_stall   = i_req && m_win != 3;
            e.mem_en    = (m_win != 0);
            e.chk_wdata = 1'b1;
            m_pend = 0;
            case (m_win)
                1: begin
                    e.mem_we = 4'hF; e.mem_addr = prog_addr / 4; e.mem_wdata = prog_wdata;
                    shadow[prog_addr[7:2]] = prog_wdata;
                end
                2: begin
                    idx = int'(d_addr[7:2]);
                    e.mem_addr = d_addr / 4;
                    if (d_we) begin
                        e.mem_we = d_be; e.mem_wdata = d_wdata;
                        for (int b = 0; b < 4; b++)
                            if (d_be[b]) shadow[idx][8*b +: 8] = d_wdata[8*b +: 8];
                    end else begin
                        e.chk_wdata = 1'b0;
                        m_pend = 1; m_pend_data = shadow[idx];
                    end
                    if (i_req && m_losses < LIMIT) m_losses++;
                end
                3: begin
                    e.mem_addr = i_addr / 4;
                    m_pend = 2; m_pend_data = shadow[i_addr[7:2]];
                    m_losses = 0;
                end
                default: ;
            endcase
        end else begin
            m_pend = 0;
            m_losses = 0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("d_gnt", 64'(d_gnt), 64'(e.d_gnt));
            chk("d_stall", 64'(d_stall), 64'(e.d_stall));
            chk("i_gnt", 64'(i_gnt), 64'(e.i_gnt));
            chk("i_stall", 64'(i_stall), 64'(e.i_stall));
            chk("mem_en", 64'(mem_en), 64'(e.mem_en));
            chk("mem_we", 64'(mem_we), 64'(e.mem_we));
            chk("mem_addr", 64'(mem_addr), 64'(e.mem_addr));
            if (e.chk_wdata || !start) chk("mem_wdata", 64'(mem_wdata), 64'(e.mem_wdata));
            chk("d_rvalid", 64'(d_rvalid), 64'(e.d_rvalid));
            chk("d_rdata", 64'(d_rdata), 64'(e.d_rdata));
            chk("i_rvalid", 64'(i_rvalid), 64'(e.i_rvalid));
            chk("i_rdata", 64'(i_rdata), 64'(e.i_rdata));
            chk("starve_cnt", 64'(dbg_starve_cnt), 64'(e.cnt));
            chk("owner", 64'(dbg_owner), 64'(e.owner));
        end
    end

    // ---------------- driver ----------------
    task automatic idle();
        prog_req = 1'b0; d_req = 1'b0; i_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic set_d(input logic we, input logic [3:0] be, input logic [31:0] a);
        d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = $urandom;
    endtask

    task automatic set_i(input logic [31:0] a);
        i_req = 1'b1; i_addr = a;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        m_pend = 0; m_losses = 0; m_win = 0; m_pend_data = 0;
        start = 1'b0; sram_load = 1'b1;
        prog_addr = 0; prog_wdata = 0; d_be = 0; d_addr = 0; d_wdata = 0; i_addr = 0;
        idle();
        @(posedge clk);
        #1;
        sram_load = 1'b0;

        // Reset with every request high: all outputs zero.
        prog_req = 1'b1; prog_addr = 32'h4; prog_wdata = 32'h11223344;
        set_d(1'b1, 4'hF, 32'h10);
        set_i(32'h14);
        repeat (3) step();

        // Release with a lone fetch at 0x100, then see it return.
        start = 1'b1; idle(); set_i(32'h100);
        step();
        idle(); step();

        // Prog overrides data and fetch; counter must hold.
        prog_req = 1'b1; prog_addr = 32'h8; prog_wdata = 32'hDEADBEEF;
        set_d(1'b0, 4'h0, 32'h8); set_i(32'h8);
        step();
        prog_req = 1'b0; step(); step(); step();

        // Starvation pattern from a clean counter.
        start = 1'b0; idle(); step();
        start = 1'b1; set_d(1'b0, 4'h0, 32'h30); set_i(32'h40);
        repeat (11) step();
        idle(); step();

        // Store then load at the same word.
        set_d(1'b1, 4'b0011, 32'h20); step();
        set_d(1'b0, 4'h0, 32'h23); step();
        idle(); step();

        // Alternating owners on consecutive cycles.
        set_d(1'b0, 4'h0, 32'h8); step();
        idle(); set_i(32'hC); step();
        idle(); step(); step();

        // Reset lands on an in-flight fetch.
        set_i(32'h44); step();
        start = 1'b0; idle(); step();
        start = 1'b1; step();

        // Randomized traffic with stall-hold discipline.
        for (int n = 0; n < 500; n++) begin
            start    = ($urandom_range(0, 63) != 0);
            prog_req = ($urandom_range(0, 7) == 0);
            if (prog_req) begin
                prog_addr = $urandom_range(0, 255); prog_wdata = $urandom;
            end
            if (!(d_req && m_win != 2)) begin
                if ($urandom_range(0, 1) == 1)
                    set_d(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          32'($urandom_range(0, 255)));
                else d_req = 1'b0;
            end
            if (!(i_req && m_win != 3)) begin
                if ($urandom_range(0, 2) != 0) set_i(32'($urandom_range(0, 255)));
                else i_req = 1'b0;
            end
            step();
        end
        idle(); start = 1'b1; step(); step();

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for a single-ported, unified, word-addressed synchronous SRAM shared by three requesters: the programming port (`prog_*`), the MEM1 data access, and the IF instruction fetch. Each cycle it grants at most one requester, drives the SRAM port, and routes read data back to the correct owner one cycle later. It raises per-requester stall signals so the hazard unit can freeze IF or MEM1 while they wait.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width of all requester addresses.
- `STARVE_LIMIT`, 4: consecutive fetch losses to data before fetch is forced to win; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `start`  in  1  reset, synchronous and active-low; block is in reset while `start`=0.
- `prog_req`  in  1  programming write request.
- `prog_addr`  in  ADDR_W  programming byte address.
- `prog_wdata`  in  32  programming write data.
- `d_req`  in  1  data access request (MEM1).
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  4  store byte enables.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_stall`  out  1  `d_req & ~d_gnt`.
- `d_rvalid`  out  1  load data valid on `d_rdata`.
- `d_rdata`  out  32  load data.
- `i_req`  in  1  fetch request.
- `i_addr`  in  ADDR_W  fetch byte address.
- `i_gnt`  out  1  fetch accepted this cycle.
- `i_stall`  out  1  `i_req & ~i_gnt`.
- `i_rvalid`  out  1  instruction valid on `i_rdata`.
- `i_rdata`  out  32  instruction word.
- `mem_en`  out  1  SRAM access enable.
- `mem_we`  out  4  SRAM byte write enables.
- `mem_addr`  out  ADDR_W-2  SRAM word address.
- `mem_wdata`  out  32  SRAM write data.
- `mem_rdata`  in  32  SRAM read data, valid the cycle after a read.

## Operation
- Grant selection is combinational from the current requests and state. Priority:
  - If `prog_req`=1, prog wins.
  - Otherwise, if `d_req`=1 and `i_req`=1, fetch wins when `starve_cnt` = STARVE_LIMIT; data wins in every other case.
  - Otherwise the single requester present wins.
- Prog grant drives `mem_en`=1, `mem_we`=4'hF, `mem_addr`=`prog_addr[ADDR_W-1:2]`, `mem_wdata`=`prog_wdata`. While prog wins, `d_gnt`=`i_gnt`=0.
- Data grant:
  - Store: `mem_we`=`d_be`.
  - Load: `mem_we`=0.
  - `mem_addr`=`d_addr[ADDR_W-1:2]`; the low two address bits are ignored.
- Fetch grant: `mem_we`=0, `mem_addr`=`i_addr[ADDR_W-1:2]`.
- No grant: `mem_en`=0, `mem_we`=0. `mem_addr` and `mem_wdata` are 0.
- `owner` register, type `arb_owner_t` = {OWN_NONE, OWN_DATA, OWN_FETCH}:
  - Next value is OWN_DATA on a data load grant, OWN_FETCH on a fetch grant, and OWN_NONE on any write or idle cycle.
- Read return: `d_rvalid` = (`owner`==OWN_DATA) and `i_rvalid` = (`owner`==OWN_FETCH).
  - `d_rdata` and `i_rdata` equal `mem_rdata` when their rvalid is 1, and 0 otherwise.
- `starve_cnt` (4 bits):
  - Increments, saturating at STARVE_LIMIT, on each cycle where data wins while `i_req`=1.
  - Clears on any fetch grant.
  - Holds on prog cycles and on all other cycles.

## Timing
- Reset (`start`=0 at an edge): `owner`=OWN_NONE and `starve_cnt`=0.
  - While `start`=0, all outputs are forced to 0: grants, stalls, rvalids, rdata and all `mem_*`.
- Reset mid-operation: a read granted in the cycle before reset produces no rvalid.
- Latency: grant in cycle N, SRAM read in N, rvalid and rdata in N+1. Writes produce no response.
- Back-to-back reads are allowed every cycle. The `owner` register pipelines the routing, so consecutive grants may alternate requesters.
- Requesters must hold their request and address stable while stalled. A grant consumes the request in the same cycle.
- Simultaneous events:
  - prog, data and fetch in one cycle: only prog is granted.
  - A forced fetch win uses the data loss slot: data stalls exactly one cycle.

## Structure
- `arb_owner_t` belongs in `riscv_defines`, beside the other shared typedefs. `STARVE_LIMIT`'s default lives there as a constant.
- Single flat module; no sub-module is warranted.
- Registers are limited to `owner` and `starve_cnt`; everything else is combinational.

## Test plan
- Reset: hold `start`=0 with all requests high → every output 0. Release reset with only `i_req`=1, `i_addr`=0x100 → `i_gnt`=1 and `mem_addr`=0x40. Next cycle `i_rvalid`=1 and `i_rdata`=`mem_rdata`.
- Prog override: `prog_req`, `d_req` and `i_req` all high, `prog_addr`=0x8, `prog_wdata`=0xDEADBEEF → `mem_we`=4'hF, `mem_addr`=2, `d_stall`=`i_stall`=1, and `starve_cnt` unchanged.
- Starvation with STARVE_LIMIT=4: `d_req`=`i_req`=1 continuously, all loads → data granted in cycles 0-3, fetch in cycle 4, data in cycles 5-8, fetch in cycle 9. The rvalids follow one cycle later, with no overlap.
- Store then load: data store with `d_be`=4'b0011 at 0x20 → `mem_we`=4'b0011 and no rvalid. Load at 0x23 next cycle → `mem_addr`=8, then `d_rvalid`=1 the cycle after.
- Alternating routing: data load, then fetch load, on consecutive cycles → `d_rvalid` in cycle N+1 and `i_rvalid` in N+2, each with the correct `mem_rdata` word.
- Reset mid-read: fetch granted in cycle N with `start`=0 at edge N+1 → `i_rvalid`=0 in N+1 and `starve_cnt`=0.
